door_lock_scheduler: RTL and testbench

Shares the single door lock actuator between several access sources, such as the keypad door controller, the RFID reader and the remote app unlock. Each source raises a level request. The block grants one source at a time in round-robin order, holds the lock open for a timed window measured in slow timebase ticks, and relocks only once the door is sensed closed. It also raises an ajar alarm if the door stays open, and gives a fire/emergency override absolute priority.

---
 rtl/door_lock_scheduler_if.sv | 26 ++
 rtl/door_lock_scheduler.sv | 157 +++++++++++++++
 tb/tb_door_lock_scheduler.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/door_lock_scheduler_if.sv
// Request/status bundle between the access sources, door sensor and the lock scheduler.
// The master drives requests and sensor inputs; the slave (scheduler) drives grants and actuator controls.
interface door_lock_scheduler_if #(
  parameter int N_REQ = 3
);
  logic             tick;
  logic [N_REQ-1:0] req;
  logic             door_closed;
  logic             emergency;
  logic [N_REQ-1:0] ack;
  logic [1:0]       grant_id;
  logic             unlock_out;
  logic             lock_pulse;
  logic             ajar_alarm;
  logic             busy;

  modport master (
    output tick, req, door_closed, emergency,
    input  ack, grant_id, unlock_out, lock_pulse, ajar_alarm, busy
  );

  modport slave (
    input  tick, req, door_closed, emergency,
    output ack, grant_id, unlock_out, lock_pulse, ajar_alarm, busy
  );
endinterface

// File: rtl/door_lock_scheduler.sv
// Round-robin owner of the door lock actuator with a tick-timed unlock window, ajar alarm and emergency override.
// All outputs registered: ack one cycle after a request is seen in IDLE; requests wait while busy.
module door_lock_scheduler #(
  parameter int N_REQ      = 3,
  parameter int HOLD_TICKS = 8,
  parameter int AJAR_TICKS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  door_lock_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, OPEN, AJAR, RELOCK, EMERG} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [1:0]       grant_id_q, grant_id_d;
  logic [1:0]       rr_last_q, rr_last_d;
  logic             unlock_q, unlock_d;
  logic             lock_pulse_q, lock_pulse_d;
  logic             ajar_q, ajar_d;
  logic             busy_q, busy_d;
  logic [3:0]       tick_cnt_q, tick_cnt_d;

  logic [3:0] req_pad;
  logic [2:0] pick;

  assign req_pad = 4'(bus.req);

  // Returns {found, index}; the search starts just after the last winner and wraps.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] sel;
    logic [2:0] pos;
    sel = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      pos = {1'b0, last} + 3'(k);
      if (pos >= 3'(N_REQ)) pos = pos - 3'(N_REQ);
      if (r[pos[1:0]]) sel = {1'b1, pos[1:0]};
    end
    return sel;
  endfunction

  assign pick = rr_pick(req_pad, rr_last_q);

  always_comb begin
    state_d      = state_q;
    ack_d        = '0;
    grant_id_d   = grant_id_q;
    rr_last_d    = rr_last_q;
    unlock_d     = unlock_q;
    lock_pulse_d = 1'b0;
    ajar_d       = ajar_q;
    tick_cnt_d   = tick_cnt_q;

    if (bus.emergency) begin
      state_d  = EMERG;
      unlock_d = 1'b1;
      ajar_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          unlock_d = 1'b0;
          ajar_d   = 1'b0;
          if (pick[2]) begin
            ack_d[pick[1:0]] = 1'b1;
            grant_id_d       = pick[1:0];
            rr_last_d        = pick[1:0];
            unlock_d         = 1'b1;
            tick_cnt_d       = '0;
            state_d          = OPEN;
          end
        end
        OPEN: begin
          unlock_d = 1'b1;
          if (bus.tick) begin
            if (tick_cnt_q == 4'(HOLD_TICKS - 1)) begin
              // door_closed is sampled in the expiry cycle itself
              if (bus.door_closed) begin
                state_d      = RELOCK;
                unlock_d     = 1'b0;
                lock_pulse_d = 1'b1;
              end else begin
                state_d    = AJAR;
                tick_cnt_d = '0;
              end
            end else begin
              tick_cnt_d = tick_cnt_q + 4'd1;
            end
          end
        end
        AJAR: begin
          if (bus.door_closed) begin
            state_d      = RELOCK;
            unlock_d     = 1'b0;
            lock_pulse_d = 1'b1;
            ajar_d       = 1'b0;
          end else begin
            unlock_d = 1'b1;
            if (bus.tick && (tick_cnt_q < 4'(AJAR_TICKS))) tick_cnt_d = tick_cnt_q + 4'd1;
            ajar_d = (tick_cnt_d == 4'(AJAR_TICKS));
          end
        end
        RELOCK: begin
          state_d  = IDLE;
          unlock_d = 1'b0;
        end
        EMERG: begin
          ajar_d = 1'b0;
          if (bus.door_closed) begin
            state_d      = RELOCK;
            unlock_d     = 1'b0;
            lock_pulse_d = 1'b1;
          end else begin
            state_d    = AJAR;
            unlock_d   = 1'b1;
            tick_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ack_q        <= '0;
      grant_id_q   <= '0;
      rr_last_q    <= 2'(N_REQ - 1);
      unlock_q     <= 1'b0;
      lock_pulse_q <= 1'b0;
      ajar_q       <= 1'b0;
      busy_q       <= 1'b0;
      tick_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      grant_id_q   <= grant_id_d;
      rr_last_q    <= rr_last_d;
      unlock_q     <= unlock_d;
      lock_pulse_q <= lock_pulse_d;
      ajar_q       <= ajar_d;
      busy_q       <= busy_d;
      tick_cnt_q   <= tick_cnt_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.unlock_out = unlock_q;
  assign bus.lock_pulse = lock_pulse_q;
  assign bus.ajar_alarm = ajar_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_door_lock_scheduler.sv
// Scoreboard bench: a phase/countdown reference model predicts grant and relock events plus actuator levels,
// and a negedge monitor compares everything the scheduler presents.
module tb_door_lock_scheduler;
  localparam int N    = 3;
  localparam int HOLD = 8;
  localparam int AJAR = 4;

  localparam int P_IDLE     = 0;
  localparam int P_WINDOW   = 1;
  localparam int P_OVERDUE  = 2;
  localparam int P_RELOCK   = 3;
  localparam int P_OVERRIDE = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  door_lock_scheduler_if #(.N_REQ(N)) bus();

  door_lock_scheduler #(.N_REQ(N), .HOLD_TICKS(HOLD), .AJAR_TICKS(AJAR)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int ack;
    int lock;
    int cyc;
  } evt_t;

  evt_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  int phase      = P_IDLE;
  int ticks_left = 0;
  int open_ticks = 0;
  int last_id    = N - 1;
  int e_grant    = 0;
  int e_unlock   = 0;
  int e_alarm    = 0;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic start_relock();
    phase    = P_RELOCK;
    e_unlock = 0;
    e_alarm  = 0;
    exp_q.push_back('{0, 1, cyc});
  endtask

  // Reference model: one call per clock edge, reading the same inputs the scheduler samples.
  task automatic model_step();
    int  r;
    int  idx;
    bit  found;
    if (!rst_n) begin
      phase = P_IDLE; ticks_left = 0; open_ticks = 0; last_id = N - 1;
      e_grant = 0; e_unlock = 0; e_alarm = 0;
      exp_q.delete();
      return;
    end
    cyc++;
    r = int'(bus.req);
    if (bus.emergency) begin
      phase = P_OVERRIDE; e_unlock = 1; e_alarm = 0;
    end else begin
      case (phase)
        P_IDLE: begin
          found = 0;
          for (int k = 1; k <= N; k++) begin
            idx = (last_id + k) % N;
            if (!found && ((r >> idx) & 1) == 1) begin
              found = 1;
              last_id = idx;
            end
          end
          if (found) begin
            e_grant = last_id; e_unlock = 1; phase = P_WINDOW; ticks_left = HOLD;
            exp_q.push_back('{1 << last_id, 0, cyc});
          end
        end
        P_WINDOW: if (bus.tick) begin
          ticks_left--;
          if (ticks_left == 0) begin
            if (bus.door_closed) start_relock();
            else begin phase = P_OVERDUE; open_ticks = 0; end
          end
        end
        P_OVERDUE: begin
          if (bus.door_closed) start_relock();
          else begin
            if (bus.tick && open_ticks < AJAR) open_ticks++;
            e_alarm = (open_ticks == AJAR) ? 1 : 0;
          end
        end
        P_RELOCK: begin phase = P_IDLE; e_unlock = 0; end
        default: begin
          if (bus.door_closed) start_relock();
          else begin phase = P_OVERDUE; open_ticks = 0; e_unlock = 1; e_alarm = 0; end
        end
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Monitor: levels every cycle, events whenever ack or lock_pulse shows up.
  initial forever begin
    evt_t ev;
    @(negedge clk);
    check("unlock_out", int'(bus.unlock_out), e_unlock);
    check("ajar_alarm", int'(bus.ajar_alarm), e_alarm);
    check("busy", int'(bus.busy), (phase != P_IDLE) ? 1 : 0);
    check("grant_id", int'(bus.grant_id), e_grant);
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check("event_missing_at_cycle", cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (bus.ack != '0 || bus.lock_pulse) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack_or_lock", int'({bus.ack, bus.lock_pulse}), 0);
      end else begin
        ev = exp_q.pop_front();
        check("ack", int'(bus.ack), ev.ack);
        check("lock_pulse", int'(bus.lock_pulse), ev.lock);
        check("event_cycle", cyc, ev.cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ticks(input int n);
    repeat (n) begin
      @(negedge clk); bus.tick = 1'b1;
      @(negedge clk); bus.tick = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [2:0] r;
    logic [2:0] m;
    bus.tick = 1'b0; bus.req = '0; bus.door_closed = 1'b1; bus.emergency = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // single grant, door closed throughout
    bus.req = 3'b001; idle(1); bus.req = '0;
    pulse_ticks(HOLD); idle(4);

    // all three requesting across several windows
    bus.req = 3'b111;
    pulse_ticks(4 * HOLD + 6);
    bus.req = '0; pulse_ticks(HOLD); idle(4);

    // door held open past the window
    bus.req = 3'b010; idle(1); bus.req = '0;
    bus.door_closed = 1'b0;
    pulse_ticks(HOLD + AJAR + 2);
    bus.door_closed = 1'b1; idle(4);

    // emergency mid-window with a request still pending
    bus.req = 3'b001; idle(1); bus.req = '0;
    pulse_ticks(3);
    bus.req = 3'b001; bus.emergency = 1'b1;
    idle(6); pulse_ticks(2);
    bus.emergency = 1'b0; idle(6);
    bus.req = '0; pulse_ticks(HOLD); idle(4);

    // a request that drops before it is granted is lost
    bus.req = 3'b001; idle(1); bus.req = '0;
    pulse_ticks(2);
    bus.req = 3'b100; idle(1); bus.req = '0;
    pulse_ticks(HOLD); idle(3);
    bus.req = 3'b010; idle(1); bus.req = '0;
    pulse_ticks(HOLD); idle(4);

    // asynchronous reset in the middle of a window
    bus.req = 3'b010; idle(1); bus.req = '0;
    pulse_ticks(3);
    @(posedge clk); #2; rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    bus.req = 3'b111; idle(2); bus.req = '0;
    pulse_ticks(HOLD); idle(4);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      r = bus.req & ~bus.ack;
      for (int b = 0; b < N; b++) begin
        m = 3'(1 << b);
        if ((r & m) == '0) begin
          if ($urandom_range(0, 9) == 0) r = r | m;
        end else if ($urandom_range(0, 63) == 0) begin
          r = r & ~m;
        end
      end
      bus.req  = r;
      bus.tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 11) == 0) bus.door_closed = ~bus.door_closed;
      if (!bus.emergency) bus.emergency = ($urandom_range(0, 199) == 0);
      else                bus.emergency = ($urandom_range(0, 11) != 0);
    end

    bus.req = '0; bus.emergency = 1'b0; bus.door_closed = 1'b1; bus.tick = 1'b0;
    idle(3);
    pulse_ticks(HOLD + 1); idle(5);
    check("events_outstanding", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
